sram_dc_initiator: RTL

Burst initiator that drives the single-port data-cache SRAM port (active-low chip select, active-low write enable, one-cycle registered read address) on behalf of a client. Accepts read or write burst commands over a valid/ready handshake, sequences one SRAM access per cycle with a wrapping address counter, and streams write data in and read data out. Sits between the cache/pipeline logic and the data-cache SRAM instance; one initiator per SRAM.

---
 rtl/sram_dc_pkg.sv | 13 +
 rtl/sram_dc_initiator_if.sv | 37 +++
 rtl/sram_dc_initiator.sv | 97 +++++++++
 3 files changed

// File: rtl/sram_dc_pkg.sv
// Shared constants and state encoding for the data-cache SRAM burst initiator.
// The width constants also size the SRAM instance so the two cannot drift apart.
package sram_dc_pkg;
    localparam int SRAM_ADDR_WIDTH = 6;
    localparam int SRAM_DATA_WIDTH = 32;
    localparam int SRAM_LEN_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;
endpackage

// File: rtl/sram_dc_initiator_if.sv
// Client command/data handshakes plus the SRAM pin bundle driven by the initiator.
// The master modport is the initiator; slave is the client/SRAM environment.
interface sram_dc_initiator_if #(
    parameter int ADDR_WIDTH = sram_dc_pkg::SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_dc_pkg::SRAM_DATA_WIDTH,
    parameter int LEN_WIDTH  = sram_dc_pkg::SRAM_LEN_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rdata_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_last;
    logic                  done;
    logic                  sram_cs_n;
    logic                  sram_wr_n;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata, sram_rdata,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
               sram_cs_n, sram_wr_n, sram_addr, sram_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wdata_valid, wdata, sram_rdata,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
               sram_cs_n, sram_wr_n, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_dc_initiator.sv
// Burst initiator for the single-port data-cache SRAM: one access per cycle,
// wrapping word address, write beats streamed in, read beats streamed out.
module sram_dc_initiator
    import sram_dc_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int LEN_WIDTH  = SRAM_LEN_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_dc_initiator_if.master bus
);
    state_e                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_req_ready;
    logic                  r_rd_pend;
    logic                  r_last_pend;
    logic                  r_wr_done;

    logic w_cs_n;
    logic w_wr_n;
    logic w_wdata_ready;
    logic w_issue;
    logic w_accept;
    logic w_final;

    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_final  = w_issue && (r_cnt == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_cs_n        = 1'b1;
        w_wr_n        = 1'b1;
        w_wdata_ready = 1'b0;
        w_issue       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) w_state_nxt = bus.req_write ? WRITE : READ;
            end
            WRITE: begin
                w_wdata_ready = 1'b1;
                if (bus.wdata_valid) begin
                    w_cs_n  = 1'b0;
                    w_wr_n  = 1'b0;
                    w_issue = 1'b1;
                    if (r_cnt == '0) w_state_nxt = IDLE;
                end
            end
            READ: begin
                w_cs_n  = 1'b0;
                w_issue = 1'b1;
                if (r_cnt == '0) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read data trails the issued address by one cycle, so the valid/last
    // flags are simply the issue qualifiers delayed by one register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rd_pend   <= 1'b0;
            r_last_pend <= 1'b0;
            r_wr_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
            if (w_accept) begin
                r_addr <= bus.req_addr;
                r_cnt  <= bus.req_len;
            end else if (w_issue) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                r_cnt  <= r_cnt - LEN_WIDTH'(1);
            end
            r_rd_pend   <= w_issue && (r_state == READ);
            r_last_pend <= w_final && (r_state == READ);
            r_wr_done   <= w_final && (r_state == WRITE);
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.wdata_ready = w_wdata_ready;
    assign bus.sram_cs_n   = w_cs_n;
    assign bus.sram_wr_n   = w_wr_n;
    assign bus.sram_addr   = r_addr;
    assign bus.sram_wdata  = bus.wdata;
    assign bus.rdata_valid = r_rd_pend;
    assign bus.rdata       = bus.sram_rdata;
    assign bus.rdata_last  = r_last_pend;
    assign bus.done        = r_wr_done | r_last_pend;
endmodule
